// File: rtl/smg_pkg.sv
// Shared constants for the multiplexed seven-segment bus: segment codes, nibble codes, FSM states.
// Latency: none (package only).
// Backpressure: none.
package smg_pkg;

  // Active-low segment codes with dp (bit7) off; shared with the display driver
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam logic [3:0] NIB_BLANK = 4'hA;
  localparam logic [3:0] NIB_ERR   = 4'hF;

  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_HOLD} state_e;

  typedef struct packed {
    logic       vld;
    logic [2:0] idx;
  } scan_t;

  // Active-low one-hot digit select -> digit index; anything else is an invalid scan
  function automatic scan_t scan_decode(input logic [5:0] scan);
    scan_t r;
    r.vld = 1'b1;
    r.idx = 3'd0;
    case (scan)
      6'b111110: r.idx = 3'd0;
      6'b111101: r.idx = 3'd1;
      6'b111011: r.idx = 3'd2;
      6'b110111: r.idx = 3'd3;
      6'b101111: r.idx = 3'd4;
      6'b011111: r.idx = 3'd5;
      default:   r.vld = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/smg_seg_decode.sv
// Segment code -> nibble decoder; dp is ignored, blank maps to NIB_BLANK, unknown codes flag err.
// Latency: combinational.
// Backpressure: none.
module smg_seg_decode
  import smg_pkg::*;
(
  input  logic [7:0] seg_i,
  output logic [3:0] nib_o,
  output logic       err_o
);

  logic [7:0] seg_nodp;
  assign seg_nodp = {1'b1, seg_i[6:0]};

  // Table lookup with dp forced off
  always_comb begin
    nib_o = NIB_ERR;
    err_o = 1'b0;
    case (seg_nodp)
      SEG_0:     nib_o = 4'd0;
      SEG_1:     nib_o = 4'd1;
      SEG_2:     nib_o = 4'd2;
      SEG_3:     nib_o = 4'd3;
      SEG_4:     nib_o = 4'd4;
      SEG_5:     nib_o = 4'd5;
      SEG_6:     nib_o = 4'd6;
      SEG_7:     nib_o = 4'd7;
      SEG_8:     nib_o = 4'd8;
      SEG_9:     nib_o = 4'd9;
      SEG_BLANK: nib_o = NIB_BLANK;
      default:   err_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/smg_capture.sv
// Snoops the 6-digit scanned seven-segment bus and reassembles the displayed 24-bit value.
// Latency: 1 input reg + SETTLE cycles per digit, commit 1 cycle after the 6th digit is sampled.
// Backpressure: none; pure monitor, number_valid is a one-cycle pulse.
module smg_capture
  import smg_pkg::*;
#(
  parameter logic [15:0] SETTLE  = 16'd8,
  parameter logic [31:0] TIMEOUT = 32'd100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  scan_sig,
  input  logic [7:0]  smg_data,
  output logic [23:0] number_out,
  output logic        number_valid,
  output logic        digit_err,
  output logic        stalled
);

  logic [5:0]  scan_r_q, scan_l_q;
  logic [7:0]  data_r_q, data_l_q;
  state_e      state_q;
  logic [15:0] cnt_q;
  logic [31:0] stall_q;
  logic [5:0]  mask_q, mask_d;
  logic [23:0] shadow_q;

  scan_t       scan_info;
  logic        scan_chg, data_chg;
  logic [3:0]  dec_nib;
  logic        dec_err;
  logic        sample, commit, mask_clr, stall_hit;

  smg_seg_decode u_dec (
    .seg_i (data_r_q),
    .nib_o (dec_nib),
    .err_o (dec_err)
  );

  assign scan_info = scan_decode(scan_r_q);
  assign scan_chg  = (scan_r_q != scan_l_q);
  assign data_chg  = (data_r_q != data_l_q);
  assign stall_hit = !scan_chg && (stall_q == TIMEOUT - 32'd1);
  assign sample    = (state_q == ST_SETTLE) && scan_info.vld && !scan_chg && !data_chg &&
                     (cnt_q == SETTLE - 16'd1);
  assign commit    = (mask_q == 6'h3F);
  // An invalid scan outside SETTLE, or a frozen bus, abandons the partial frame
  assign mask_clr  = stall_hit || ((state_q != ST_SETTLE) && !scan_info.vld);

  // Next capture mask: commit empties it, a sample adds its digit, aborts win over both
  always_comb begin
    mask_d = commit ? 6'h00 : mask_q;
    if (sample) mask_d = mask_d | (6'b000001 << scan_info.idx);
    if (mask_clr) mask_d = 6'h00;
  end

  // Input registers plus one delayed copy for change detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_r_q <= 6'h3F;
      scan_l_q <= 6'h3F;
      data_r_q <= 8'hFF;
      data_l_q <= 8'hFF;
    end else begin
      scan_r_q <= scan_sig;
      scan_l_q <= scan_r_q;
      data_r_q <= smg_data;
      data_l_q <= data_r_q;
    end
  end

  // Capture FSM, frame assembly, commit and stall watchdog
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 16'd0;
      stall_q      <= 32'd0;
      mask_q       <= 6'h00;
      shadow_q     <= 24'h0;
      number_out   <= 24'h0;
      number_valid <= 1'b0;
      digit_err    <= 1'b0;
      stalled      <= 1'b0;
    end else begin
      number_valid <= 1'b0;
      digit_err    <= 1'b0;
      mask_q       <= mask_d;

      if (commit) begin
        number_out   <= shadow_q;
        number_valid <= 1'b1;
      end

      if (sample) begin
        shadow_q[{scan_info.idx, 2'b00} +: 4] <= dec_nib;
        digit_err <= dec_err;
      end

      if (scan_chg) begin
        stall_q <= 32'd0;
        stalled <= 1'b0;
      end else if (stall_q != TIMEOUT) begin
        stall_q <= stall_q + 32'd1;
        if (stall_hit) stalled <= 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          // While stalled, wait for the scan to move before capturing again
          if (scan_info.vld && !(stalled && !scan_chg)) begin
            state_q <= ST_SETTLE;
            cnt_q   <= 16'd0;
          end
        end
        ST_SETTLE: begin
          if (!scan_info.vld) begin
            state_q <= ST_IDLE;
          end else if (scan_chg || data_chg) begin
            cnt_q <= 16'd0;
          end else if (sample) begin
            state_q <= ST_HOLD;
            cnt_q   <= 16'd0;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        ST_HOLD: begin
          if (!scan_info.vld) begin
            state_q <= ST_IDLE;
          end else if (scan_chg) begin
            state_q <= ST_SETTLE;
            cnt_q   <= 16'd0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      if (stall_hit) state_q <= ST_IDLE;
    end
  end

endmodule

// File: tb/tb_smg_capture.sv
// Bench for smg_capture: directed and random display scans checked against a table-driven model.
// Latency: n/a.
// Backpressure: n/a.
module tb_smg_capture;

  localparam int          DP = 60;
  localparam logic [15:0] ST = 16'd8;
  localparam logic [31:0] TO = 32'd200;
  localparam logic [7:0]  SEG_TAB [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                           8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
  localparam logic [7:0]  BAD_TAB [3]  = '{8'hAA, 8'hC1, 8'h55};

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  scan_sig;
  logic [7:0]  smg_data;
  logic [23:0] number_out;
  logic        number_valid, digit_err, stalled;

  int checks = 0, failures = 0;
  int vld_cnt = 0, err_cnt = 0;
  logic [23:0] last_out = 24'h0;

  always #5 clk = ~clk;

  smg_capture #(.SETTLE(ST), .TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .scan_sig     (scan_sig),
    .smg_data     (smg_data),
    .number_out   (number_out),
    .number_valid (number_valid),
    .digit_err    (digit_err),
    .stalled      (stalled)
  );

  // Output monitor, sampled on the inactive edge
  always @(negedge clk) begin
    if (number_valid) begin
      vld_cnt++;
      last_out = number_out;
    end
    if (digit_err) err_cnt++;
  end

  // Reference decode: search the digit table with dp forced off
  function automatic logic [3:0] nib_of(input logic [7:0] code);
    logic [7:0] f;
    f = {1'b1, code[6:0]};
    nib_of = 4'hF;
    for (int i = 0; i < 10; i++) if (f == SEG_TAB[i]) nib_of = 4'(i);
    if (f == 8'hFF) nib_of = 4'hA;
  endfunction

  function automatic logic [23:0] exp_val(input logic [47:0] c);
    exp_val = 24'h0;
    for (int k = 0; k < 6; k++) exp_val[4*k +: 4] = nib_of(c[8*k +: 8]);
  endfunction

  function automatic int exp_errs(input logic [47:0] c);
    exp_errs = 0;
    for (int k = 0; k < 6; k++) if (nib_of(c[8*k +: 8]) == 4'hF) exp_errs++;
  endfunction

  function automatic logic [47:0] make_codes(input logic [23:0] nibs);
    logic [3:0] n;
    make_codes = 48'h0;
    for (int k = 0; k < 6; k++) begin
      n = nibs[4*k +: 4];
      make_codes[8*k +: 8] = (n < 4'd10) ? SEG_TAB[n] : 8'hFF;
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic show_raw(input logic [5:0] scan, input logic [7:0] code, input int n);
    scan_sig = scan;
    smg_data = code;
    repeat (n) @(negedge clk);
  endtask

  task automatic show_digit(input int k, input logic [7:0] code, input int n);
    show_raw(~(6'd1 << k), code, n);
  endtask

  task automatic show_range(input logic [47:0] c, input int lo, input int hi);
    for (int k = lo; k <= hi; k++) show_digit(k, c[8*k +: 8], DP);
  endtask

  task automatic frame_check(input string tag, input logic [47:0] c);
    int v0, e0;
    v0 = vld_cnt;
    e0 = err_cnt;
    show_range(c, 0, 5);
    #1;
    check({tag, "_vld"}, vld_cnt - v0, 1);
    check({tag, "_val"}, {8'h0, last_out}, {8'h0, exp_val(c)});
    check({tag, "_err"}, err_cnt - e0, exp_errs(c));
  endtask

  initial begin
    logic [47:0] c;
    int v0, r;

    rst      = 1'b1;
    scan_sig = 6'h3F;
    smg_data = 8'hFF;
    repeat (3) @(negedge clk);
    #1;
    check("rst_out",     {8'h0, number_out}, 32'h0);
    check("rst_valid",   {31'h0, number_valid}, 32'h0);
    check("rst_err",     {31'h0, digit_err}, 32'h0);
    check("rst_stalled", {31'h0, stalled}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Clean repeated scans of a fixed value
    c = make_codes(24'h123456);
    repeat (3) frame_check("t1", c);

    // Blank on digit5
    frame_check("t2", make_codes(24'hA09876));

    // Undecodable code on digit2
    c = make_codes(24'h123456);
    c[23:16] = 8'hAA;
    repeat (2) frame_check("t3", c);

    // Glitch early in digit0 settle: data must be stable SETTLE cycles, final value wins
    c = make_codes(24'h123455);
    v0 = vld_cnt;
    show_digit(0, 8'h92, 2);
    show_digit(0, 8'hF8, 7);
    show_digit(0, 8'h92, DP - 9);
    show_range(c, 1, 5);
    #1;
    check("t4_vld", vld_cnt - v0, 1);
    check("t4_val", {8'h0, last_out}, 32'h123455);

    // Invalid scan mid-frame throws away the partial frame
    c = make_codes(24'h314159);
    frame_check("t5a", c);
    v0 = vld_cnt;
    show_range(c, 0, 2);
    show_raw(6'b111100, 8'hC0, 20);
    show_range(c, 3, 5);
    #1;
    check("t5_novld", vld_cnt - v0, 0);
    v0 = vld_cnt;
    show_range(c, 0, 5);
    #1;
    check("t5_vld", vld_cnt - v0, 1);
    check("t5_val", {8'h0, last_out}, 32'h314159);
    show_raw(6'h3F, 8'hFF, 5);

    // Frozen scan -> stalled, partial frame dropped, recovery on next scan change
    c = make_codes(24'h271828);
    show_range(c, 0, 2);
    show_digit(3, c[31:24], 100);
    #1;
    check("t6_prestall", {31'h0, stalled}, 32'h0);
    show_digit(3, c[31:24], int'(TO));
    #1;
    check("t6_stalled", {31'h0, stalled}, 32'h1);
    v0 = vld_cnt;
    show_range(c, 4, 5);
    #1;
    check("t6_unstall", {31'h0, stalled}, 32'h0);
    check("t6_novld", vld_cnt - v0, 0);
    v0 = vld_cnt;
    show_range(c, 0, 5);
    #1;
    check("t6_vld", vld_cnt - v0, 1);
    check("t6_val", {8'h0, last_out}, 32'h271828);
    show_raw(6'h3F, 8'hFF, 5);

    // Reset mid-frame
    c = make_codes(24'h864209);
    frame_check("t7a", c);
    show_range(c, 0, 2);
    rst = 1'b1;
    #1;
    check("t7_rst_out", {8'h0, number_out}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    v0 = vld_cnt;
    show_range(c, 3, 5);
    #1;
    check("t7_novld", vld_cnt - v0, 0);
    check("t7_out0", {8'h0, number_out}, 32'h0);
    show_raw(6'h3F, 8'hFF, 5);
    frame_check("t7b", c);

    // Random frames: digits, blanks, dp-lit digits, bad codes
    repeat (8) begin
      for (int k = 0; k < 6; k++) begin
        r = int'($urandom_range(0, 15));
        if (r < 10)      c[8*k +: 8] = SEG_TAB[r];
        else if (r < 12) c[8*k +: 8] = 8'hFF;
        else if (r == 12) c[8*k +: 8] = BAD_TAB[$urandom_range(0, 2)];
        else             c[8*k +: 8] = SEG_TAB[$urandom_range(0, 9)] & 8'h7F;
      end
      frame_check("rnd", c);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
